// File: rtl/cla28_share_arb_if.sv
// Requester handshakes and the result stage of the shared 28-bit adder arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/consumer side.
interface cla28_share_arb_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [27:0] i_req0_a;
  logic [27:0] i_req0_b;
  logic        i_req0_sub;
  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [27:0] i_req1_a;
  logic [27:0] i_req1_b;
  logic        i_req1_sub;
  logic        o_valid;
  logic        i_ready;
  logic [27:0] o_sum;
  logic        o_carry;
  logic        o_id;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_sub,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_sub,
    input  i_ready,
    output o_req0_ready, o_req1_ready,
    output o_valid, o_sum, o_carry, o_id
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_sub,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_sub,
    output i_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_valid, o_sum, o_carry, o_id
  );
endinterface

// File: rtl/cla28_share_arb.sv
// Round-robin arbiter sharing one combinational 28-bit carry-lookahead adder between two
// add/sub requesters, with a single-entry registered result stage and per-requester grant counters.
module cla28_adder (
  input  logic [27:0] i_a,
  input  logic [27:0] i_b,
  input  logic        i_cin,
  output logic [27:0] o_sum,
  output logic        o_cout
);
  logic [27:0] w_g;
  logic [27:0] w_p;
  logic [27:0] w_c;
  logic [7:0]  w_gc;

  // Seven 4-bit lookahead groups; group carries chain through group generate/propagate.
  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_c  = '0;
    w_gc = '0;
    w_gc[0] = i_cin;
    for (int k = 0; k < 7; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
    o_sum  = w_p ^ w_c;
    o_cout = w_gc[7];
  end
endmodule

module cla28_share_arb #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cla28_share_arb_if.slave bus,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
);
  localparam int DATA_W = 28;

  logic              r_valid_p1;
  logic [DATA_W-1:0] r_sum_p1;
  logic              r_carry_p1;
  logic              r_id_p1;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_load_ok;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_acc;
  logic [DATA_W-1:0] w_a_p0;
  logic [DATA_W-1:0] w_b_p0;
  logic              w_sub_p0;
  logic [DATA_W-1:0] w_sum_p0;
  logic              w_carry_p0;

  // Stage p0: grant, operand select and the shared adder.
  assign w_load_ok = ~r_valid_p1 | bus.i_ready;
  assign w_gnt0    = bus.i_req0_valid & (~bus.i_req1_valid | r_last);
  assign w_gnt1    = bus.i_req1_valid & (~bus.i_req0_valid | ~r_last);
  assign w_acc0    = bus.i_req0_valid & w_gnt0 & w_load_ok;
  assign w_acc1    = bus.i_req1_valid & w_gnt1 & w_load_ok;
  assign w_acc     = w_acc0 | w_acc1;

  assign w_a_p0    = w_gnt1 ? bus.i_req1_a   : bus.i_req0_a;
  assign w_sub_p0  = w_gnt1 ? bus.i_req1_sub : bus.i_req0_sub;
  assign w_b_p0    = (w_gnt1 ? bus.i_req1_b : bus.i_req0_b) ^ {DATA_W{w_sub_p0}};

  cla28_adder u_cla (
    .i_a    (w_a_p0),
    .i_b    (w_b_p0),
    .i_cin  (w_sub_p0),
    .o_sum  (w_sum_p0),
    .o_cout (w_carry_p0)
  );

  // Stage p1: single-entry result register; a drain and a load may share one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid_p1 <= 1'b0;
      r_sum_p1   <= '0;
      r_carry_p1 <= 1'b0;
      r_id_p1    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      r_valid_p1 <= w_acc | (r_valid_p1 & ~bus.i_ready);
      if (w_acc) begin
        r_sum_p1   <= w_sum_p0;
        r_carry_p1 <= w_carry_p0;
        r_id_p1    <= w_acc1;
        r_last     <= w_acc1;
      end
      if (w_acc0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_acc1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign bus.o_req0_ready = w_gnt0 & w_load_ok;
  assign bus.o_req1_ready = w_gnt1 & w_load_ok;
  assign bus.o_valid      = r_valid_p1;
  assign bus.o_sum        = r_sum_p1;
  assign bus.o_carry      = r_carry_p1;
  assign bus.o_id         = r_id_p1;
  assign o_cnt0           = r_cnt0;
  assign o_cnt1           = r_cnt1;
endmodule

// File: doc/cla28_share_arb.md
# cla28_share_arb

Two-requester arbiter and sequencer for one shared 28-bit carry-lookahead adder (CLA_28bit) in the floating-point mantissa path. Each requester issues add or subtract operations through a valid/ready handshake. The block grants one requester per cycle in round-robin order, drives the adder operands and carry-in for the selected operation, and registers the result, carry and requester ID into a single-entry output stage with downstream backpressure. Per-requester grant counters are kept for performance monitoring.

## Interface
- CNT_W, 16, width of each grant counter
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req0_valid  in  1  requester 0 has an operation
- o_req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- i_req0_a  in  28  requester 0 operand A
- i_req0_b  in  28  requester 0 operand B
- i_req0_sub  in  1  requester 0 op: 0 = A+B, 1 = A-B
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_sub: same as requester 0, for requester 1
- o_valid  out  1  result register holds a result
- i_ready  in  1  downstream consumes the result when high with o_valid
- o_sum  out  28  registered adder sum
- o_carry  out  1  registered adder carry-out; for subtract, 1 = no borrow (A >= B unsigned)
- o_id  out  1  requester that issued the held result
- o_cnt0  out  CNT_W  grants issued to requester 0
- o_cnt1  out  CNT_W  grants issued to requester 1

## Operation
- One CLA_28bit instance, fully combinational.
- Adder inputs from the granted requester:
  - add: a = A, b = B, carry-in = 0
  - sub: a = A, b = ~B, carry-in = 1
- Output stage can load (`load_ok`) when `~o_valid | i_ready`.
- Grant logic is combinational from the valids and a 1-bit `last` register (last granted requester):
  - only one valid: grant it
  - both valid: grant `~last`
  - none valid: no grant
- `o_reqK_ready = grantK & load_ok`.
- Accept (transfer) on requester K = `i_reqK_valid & o_reqK_ready`. On accept:
  - o_sum, o_carry and o_id load from the adder and K
  - o_valid is set
  - `last` becomes K
  - o_cntK increments, wrapping from 2^CNT_W-1 to 0
- No accept while `o_valid & i_ready`: o_valid clears. Otherwise o_valid holds, and o_sum, o_carry, o_id hold while not loading.
- `last` and the counters change only on an accept.
- Requesters must hold valid and operands stable until accepted. The block may drop readiness while a requester waits; no combinational path from ready into a requester's valid is permitted.
- Starvation bound: with both requesters continuously valid and downstream always ready, grants strictly alternate.
- Reset values:
  - o_valid = 0, o_sum = 0, o_carry = 0, o_id = 0
  - `last` = 1, so requester 0 wins the first contention
  - o_cnt0 = o_cnt1 = 0
- Reset mid-operation: an in-flight result is discarded, with no handshake completion implied.

## Timing
- Latency: accept in cycle N, result visible with o_valid = 1 after the edge ending cycle N, i.e. in cycle N+1.
- Throughput: one operation per cycle when i_ready stays high.
- Simultaneous drain and load: with o_valid & i_ready in the same cycle as an accept, the old result is consumed and the new one loaded on the same edge. o_valid stays 1 with no bubble.
- Backpressure: with o_valid = 1 and i_ready = 0, both readies are 0 and the output registers, `last` and counters hold.
- Readies are combinational from the valids, i_ready, o_valid and `last`. All other outputs are registered.
- The counters update on the same edge as the result load.

## Test plan
- Reset, then idle: all outputs 0 after i_rst, and o_req0_ready = o_req1_ready = 0 with no valids.
- Single add: req0 A=0x0FFFFFF, B=0x0000001, sub=0 -> next cycle o_valid=1, o_sum=0x1000000, o_carry=0, o_id=0, o_cnt0=1.
- Subtract and borrow, on requester 1:
  - A=5, B=3, sub=1 -> o_sum=2, o_carry=1
  - A=3, B=5, sub=1 -> o_sum=0xFFFFFFE, o_carry=0, o_id=1
- Contention: both valid for 4 cycles with i_ready=1 -> grants in order 0,1,0,1; o_cnt0=o_cnt1=2; o_valid stays high with no bubble.
- Backpressure: hold i_ready=0 for 3 cycles with both valid -> o_sum/o_id/counters frozen, readies 0. Release -> the next grant goes to `~last` and the result updates on the following cycle.
- Wrap and async reset:
  - with CNT_W=4, 16 grants to req0 -> o_cnt0 returns to 0
  - assert i_rst mid-stream, not aligned to an edge -> o_valid drops immediately and `last` resets so req0 wins the next contention.
